// File: rtl/counter_job_launcher.sv
// Request FIFO plus three-state launcher feeding a run/count counter stage.
// Optional WAIT watchdog enabled by defining COUNTER_JOB_LAUNCHER_TIMEOUT_EN.
module counter_job_launcher #(
  parameter int DEPTH   = 4,
  parameter int NUM_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [NUM_W-1:0] i_num,
  output logic             o_ready,
  output logic             o_run,
  output logic [NUM_W-1:0] o_num,
  input  logic             i_done,
  output logic             o_busy,
  output logic [7:0]       o_jobs_done,
  output logic             o_zero_drop,
  output logic             o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_param
    $error("counter_job_launcher: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [7:0]       jobs_q, jobs_d;
  logic             zero_drop_q, zero_drop_d;
  logic [NUM_W-1:0] mem [DEPTH];
  logic [NUM_W-1:0] head;
  logic [AW:0]      fifo_count;
  logic             fifo_empty;
  logic             accept;
  logic             push;
  logic             pop;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = mem[rd_ptr_q[AW-1:0]];

  assign o_ready = (fifo_count != FULL_CNT);
  assign accept  = i_valid && o_ready;
  // Zero-length requests are consumed but never queued: the counter cannot run them.
  assign push    = accept && (i_num != '0);

`ifdef COUNTER_JOB_LAUNCHER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  logic [WDW-1:0] wd_q, wd_d;
  logic           expire;
`endif

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    jobs_d      = jobs_q;
    pop         = 1'b0;
    zero_drop_d = accept && (i_num == '0);
`ifdef COUNTER_JOB_LAUNCHER_TIMEOUT_EN
    wd_d   = wd_q;
    expire = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LAUNCH;
      end
      LAUNCH: begin
        pop     = 1'b1;
        num_d   = head;
        state_d = WAIT;
`ifdef COUNTER_JOB_LAUNCHER_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      WAIT: begin
        if (i_done) begin
          state_d = IDLE;
          jobs_d  = jobs_q + 8'd1;
        end
`ifdef COUNTER_JOB_LAUNCHER_TIMEOUT_EN
        // A done pulse in the expiry cycle still counts the job.
        else if (wd_q == WD_LIMIT) begin
          expire  = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      num_q       <= '0;
      jobs_q      <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      num_q       <= num_d;
      jobs_q      <= jobs_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= i_num;
  end

`ifdef COUNTER_JOB_LAUNCHER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign o_timeout = expire;
`else
  assign o_timeout = 1'b0;
`endif

  // The head is shown during LAUNCH so o_num is valid alongside the run pulse.
  assign o_run       = (state_q == LAUNCH);
  assign o_num       = (state_q == LAUNCH) ? head : num_q;
  assign o_busy      = (state_q != IDLE) || !fifo_empty;
  assign o_jobs_done = jobs_q;
  assign o_zero_drop = zero_drop_q;

endmodule

// File: tb/tb_counter_job_launcher.sv
// Self-checking bench for counter_job_launcher: directed scenarios, a vector
// table and a randomized run against a queue-based reference model.
module tb_counter_job_launcher;

  localparam int DEPTH = 4;
  localparam int NUM_W = 4;

  logic             clk;
  logic             reset;
  logic             i_valid;
  logic [NUM_W-1:0] i_num;
  logic             o_ready;
  logic             o_run;
  logic [NUM_W-1:0] o_num;
  logic             i_done;
  logic             o_busy;
  logic [7:0]       o_jobs_done;
  logic             o_zero_drop;
  logic             o_timeout;

  int total = 0;
  int bad   = 0;

  counter_job_launcher #(.DEPTH(DEPTH), .NUM_W(NUM_W), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_num       (i_num),
    .o_ready     (o_ready),
    .o_run       (o_run),
    .o_num       (o_num),
    .i_done      (i_done),
    .o_busy      (o_busy),
    .o_jobs_done (o_jobs_done),
    .o_zero_drop (o_zero_drop),
    .o_timeout   (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int n;
    bit d;
    bit run;
    int num;
    bit rdy;
    bit busy;
    int jobs;
    bit zd;
  } vec_t;

  vec_t vecs[13];

  // Reference model state: the pending queue plus where the launcher is in its job.
  int q[$];
  bit m_launch;
  bit m_inflight;
  bit m_zd;
  int m_last;
  int m_jobs;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    i_num   = '0;
    i_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic model_clear();
    q.delete();
    m_launch   = 1'b0;
    m_inflight = 1'b0;
    m_zd       = 1'b0;
    m_last     = 0;
    m_jobs     = 0;
  endtask

  task automatic model_step(input bit v, input int n, input bit d);
    bit acc;
    acc  = v && (q.size() < DEPTH);
    m_zd = acc && (n == 0);
    if (m_launch) begin
      m_last     = q.pop_front();
      m_launch   = 1'b0;
      m_inflight = 1'b1;
    end else if (m_inflight) begin
      if (d) begin
        m_inflight = 1'b0;
        m_jobs     = (m_jobs + 1) % 256;
      end
    end else if (q.size() > 0) begin
      m_launch = 1'b1;
    end
    if (acc && n != 0) q.push_back(n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int exp_b[6];
    int idx;
    int launches;
    int tmr;
    bit saw_full;
    int e_num;
    bit v;
    int n;
    bit d;

    // Single request of 5 at cycle 10; counter answers at cycle 18.
    do_reset();
    chk("reset.ready", o_ready, 1);
    chk("reset.busy", o_busy, 0);
    chk("reset.jobs", o_jobs_done, 0);
    chk("reset.num", o_num, 0);
    chk("reset.zd", o_zero_drop, 0);
    chk("reset.timeout", o_timeout, 0);
    for (int c = 0; c < 26; c++) begin
      chk($sformatf("single.run.c%0d", c), o_run, (c == 12) ? 1 : 0);
      if (c == 12) chk("single.num", o_num, 5);
      if (c == 19) begin
        chk("single.jobs", o_jobs_done, 1);
        chk("single.busy", o_busy, 0);
      end
      i_valid = (c == 10);
      i_num   = 4'd5;
      i_done  = (c == 18);
      tick();
    end
    i_valid = 1'b0;
    i_done  = 1'b0;
    $display("single request: jobs=%0d", o_jobs_done);

    // Burst while a job of 15 is in flight, so the queue fills and back-pressures.
    do_reset();
    exp_b    = '{15, 3, 7, 2, 9, 4};
    idx      = 0;
    launches = 0;
    tmr      = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 300 && !(launches == 6 && o_jobs_done == 6); c++) begin
      if (o_run) begin
        if (launches < 6) chk($sformatf("burst.order%0d", launches), o_num, exp_b[launches]);
        else              chk("burst.extra_launch", 1, 0);
        launches++;
      end
      i_done = 1'b0;
      if (o_run) tmr = 10;
      else if (tmr > 0) begin
        tmr--;
        if (tmr == 0) i_done = 1'b1;
      end
      if (idx == 0) i_valid = (c == 0);
      else          i_valid = (c >= 3) && (idx < 6);
      i_num = (idx < 6) ? NUM_W'(exp_b[idx]) : '0;
      if (i_valid && !o_ready) saw_full = 1'b1;
      if (i_valid && o_ready) idx++;
      tick();
    end
    i_valid = 1'b0;
    i_done  = 1'b0;
    chk("burst.launches", launches, 6);
    chk("burst.jobs", o_jobs_done, 6);
    chk("burst.ready_dropped", saw_full, 1);
    chk("burst.all_accepted", idx, 6);
    $display("burst: launches=%0d jobs=%0d", launches, o_jobs_done);

    // Reset in the middle of WAIT with three jobs still queued.
    for (int c = 0; c < 8; c++) begin
      i_valid = (c < 4);
      i_num   = NUM_W'(c + 1);
      i_done  = 1'b0;
      tick();
    end
    i_valid = 1'b0;
    chk("midreset.pre_busy", o_busy, 1);
    chk("midreset.pre_jobs", o_jobs_done, 6);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset.run", o_run, 0);
    chk("midreset.num", o_num, 0);
    chk("midreset.jobs", o_jobs_done, 0);
    chk("midreset.busy", o_busy, 0);
    chk("midreset.ready", o_ready, 1);
    chk("midreset.zd", o_zero_drop, 0);
    chk("midreset.timeout", o_timeout, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("postreset.run.c%0d", c), o_run, 0);
      chk($sformatf("postreset.busy.c%0d", c), o_busy, 0);
      tick();
    end
    $display("mid-WAIT reset: outputs cleared, no launch afterwards");

    // Zero-request drop between 6 and 1, with spurious and doubled done pulses.
    //          v  n  d  run num rdy busy jobs zd
    vecs[0]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    vecs[1]  = '{1, 6, 0, 0, 0, 1, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{1, 1, 0, 1, 6, 1, 1, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 6, 1, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 6, 1, 1, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 6, 1, 1, 1, 0};
    vecs[7]  = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    vecs[9]  = '{0, 0, 1, 0, 1, 1, 1, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 1, 1, 0, 2, 0};
    vecs[11] = '{0, 0, 1, 0, 1, 1, 0, 2, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 1, 0, 2, 0};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d.run", i), o_run, vecs[i].run);
      chk($sformatf("vec%0d.num", i), o_num, vecs[i].num);
      chk($sformatf("vec%0d.ready", i), o_ready, vecs[i].rdy);
      chk($sformatf("vec%0d.busy", i), o_busy, vecs[i].busy);
      chk($sformatf("vec%0d.jobs", i), o_jobs_done, vecs[i].jobs);
      chk($sformatf("vec%0d.zd", i), o_zero_drop, vecs[i].zd);
      i_valid = vecs[i].v;
      i_num   = NUM_W'(vecs[i].n);
      i_done  = vecs[i].d;
      tick();
    end
    i_valid = 1'b0;
    i_done  = 1'b0;
    $display("vector table: 13 cycles applied, jobs=%0d", o_jobs_done);

    // Randomized traffic against the reference model.
    do_reset();
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      e_num = m_launch ? q[0] : m_last;
      chk($sformatf("rand.run.c%0d", c), o_run, m_launch);
      chk($sformatf("rand.num.c%0d", c), o_num, e_num);
      chk($sformatf("rand.ready.c%0d", c), o_ready, (q.size() < DEPTH) ? 1 : 0);
      chk($sformatf("rand.busy.c%0d", c), o_busy, (m_launch || m_inflight || q.size() != 0) ? 1 : 0);
      chk($sformatf("rand.jobs.c%0d", c), o_jobs_done, m_jobs);
      chk($sformatf("rand.zd.c%0d", c), o_zero_drop, m_zd);
      chk($sformatf("rand.timeout.c%0d", c), o_timeout, 0);
      v = ($urandom % 3) != 0;
      n = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 15));
      d = ($urandom % 5) == 0;
      i_valid = v;
      i_num   = NUM_W'(n);
      i_done  = d;
      model_step(v, n, d);
      tick();
    end
    i_valid = 1'b0;
    i_done  = 1'b0;
    $display("random: 3000 cycles, jobs=%0d", o_jobs_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_job_launcher.md
Name: counter_job_launcher

Overview:
- Upstream sequencer for the run/count counter stage.
- Accepts count requests over a valid/ready handshake and buffers them in a small FIFO.
- Launches one request at a time into the counter: one-cycle run pulse plus a held count value.
- Waits for the counter's done pulse before launching the next request, and keeps a completed-job tally.

Parameters:
- DEPTH, 4, request FIFO depth; power of 2, minimum 2.
- NUM_W, 4, width of a count request and of o_num.
- TIMEOUT, 64, WAIT-state watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  request valid.
- i_num  input  NUM_W  requested count; sampled on handshake.
- o_ready  output  1  FIFO can accept a request; equals (fifo_count != DEPTH).
- o_run  output  1  one-cycle launch pulse to the counter's run input.
- o_num  output  NUM_W  count value to the counter; held from launch until the next launch.
- i_done  input  1  one-cycle completion pulse from the counter's DONE state.
- o_busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
- o_jobs_done  output  8  completed-job count; wraps 255 -> 0.
- o_zero_drop  output  1  one-cycle pulse: a request with i_num == 0 was discarded.
- o_timeout  output  1  one-cycle pulse on watchdog expiry; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FIFO emptied; queued requests are lost.
  - State = IDLE.
  - o_run, o_num, o_jobs_done, o_zero_drop, o_timeout = 0; o_busy = 0; o_ready = 1.
- Handshake:
  - A transfer occurs in any cycle where i_valid && o_ready.
  - A transfer with i_num != 0 is pushed into the FIFO.
  - A transfer with i_num == 0 is accepted but not stored: o_zero_drop = 1 in the next cycle, and the job is not counted. Reason: the counter's terminal compare (num - 1) underflows at 0.
  - o_ready depends only on FIFO occupancy, never on i_valid.
- FIFO:
  - Circular buffer with log2(DEPTH)+1-bit pointers.
  - A push and a pop in the same cycle are both legal and leave occupancy unchanged.
  - Full: o_ready = 0 and no push occurs.
  - Empty: no pop occurs.
- FSM (state register, three states):
  - IDLE: if the FIFO is non-empty -> LAUNCH; otherwise stay.
  - LAUNCH (exactly one cycle): o_run = 1; o_num <= FIFO head, registered at the LAUNCH->WAIT edge and valid from the LAUNCH cycle; pop the head; -> WAIT.
  - WAIT: on i_done -> IDLE and increment o_jobs_done; otherwise stay.
- Launch timing:
  - o_run is decoded from the state register (state == LAUNCH), so it is glitch-free and exactly one cycle wide.
  - o_num is stable throughout WAIT.
- Latency:
  - Request accepted at cycle t into an empty FIFO with FSM in IDLE: push at t, IDLE sees non-empty at t+1, o_run at t+2.
  - i_done at cycle t: IDLE at t+1, next o_run at t+2 at the earliest. The counter is back in its IDLE state at t+1, so the pulse is never lost.
- i_done received outside WAIT is ignored: no state change, no tally change.
- A request pushed during WAIT waits in the FIFO; strict FIFO order is preserved.

Optional Feature:
- Macro: COUNTER_JOB_LAUNCHER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no i_done: o_timeout = 1 for one cycle, FSM -> IDLE, o_jobs_done unchanged, and the job is abandoned.
  - i_done arriving in the same cycle as expiry wins: the job is counted and there is no timeout.
- Not defined:
  - No counter logic.
  - o_timeout constant 0.
  - WAIT is held indefinitely until i_done.

Test Plan:
- Reset then single request i_num=5 at cycle 10:
  - o_run high only at cycle 12, with o_num=5.
  - Bench counter model returns i_done at cycle 18; o_jobs_done becomes 1 at cycle 19; o_busy low at cycle 19.
- Burst of 5 requests (3, 7, 2, 9, 4) with i_valid held high, DEPTH=4, counter held busy:
  - o_ready drops after the FIFO fills; the 5th request is held until a pop.
  - Launches occur in order 3, 7, 2, 9, 4; final o_jobs_done = 5.
- Request with i_num=0 between i_num=6 and i_num=1:
  - o_zero_drop pulses once.
  - Only 6 and 1 are launched; o_jobs_done = 2.
- Spurious i_done in IDLE and a double i_done pulse in WAIT:
  - The tally increments exactly once per launch.
  - The second pulse, now in IDLE, is ignored.
- Reset asserted mid-WAIT with 3 jobs queued:
  - All outputs return to reset values immediately (asynchronously).
  - No o_run occurs after release until a new request arrives.
- With COUNTER_JOB_LAUNCHER_TIMEOUT_EN and TIMEOUT=8, counter never returns i_done:
  - o_timeout pulses 8 cycles after WAIT entry.
  - FSM returns to IDLE; the next queued job launches 2 cycles later; o_jobs_done unchanged.
